// File: rtl/run_monitor.sv
// Store-bus monitor: watches the processor write bus for a tohost store and
// produces a PASS/FAIL/TIMEOUT verdict, cycle/store counters and a store log.
module run_monitor #(
    parameter logic [31:0] TOHOST_ADDR    = 32'h0000_00FC,
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter int          LOG_DEPTH      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        log_pop,
    output logic        done,
    output logic        pass,
    output logic        timed_out,
    output logic [31:0] fail_code,
    output logic [31:0] cycle_count,
    output logic [31:0] store_count,
    output logic [31:0] log_adr,
    output logic [31:0] log_data,
    output logic        log_empty,
    output logic        log_full,
    output logic        log_overflow
);

    localparam int              AW        = $clog2(LOG_DEPTH);
    localparam int              CW        = AW + 1;
    localparam logic [31:0]     TIMEOUT_C = 32'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]   DEPTH_C   = CW'(LOG_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    state_t         state_r, state_s;
    logic [31:0]    fail_code_r, fail_code_s;
    logic [31:0]    cycle_count_r, cyc_inc_s;
    logic [31:0]    store_count_r;
    logic           tohost_s;
    logic [63:0]    mem_r [LOG_DEPTH];
    logic [AW-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]  count_r;
    logic           overflow_r;
    logic           push_s, pop_s, full_s, wr_en_s;

    // Verdict next-state: tohost PASS/FAIL outranks timeout on the same edge
    always_comb begin
        state_s     = state_r;
        fail_code_s = fail_code_r;
        cyc_inc_s   = cycle_count_r + 32'd1;
        tohost_s    = MemWrite && (Adr == TOHOST_ADDR);
        case (state_r)
            ST_RUN: begin
                if (tohost_s && (WriteData == 32'd1)) begin
                    state_s = ST_PASS;
                end else if (tohost_s && (WriteData != 32'd0)) begin
                    state_s     = ST_FAIL;
                    fail_code_s = WriteData;
                end else if (cyc_inc_s == TIMEOUT_C) begin
                    state_s = ST_TIMEOUT;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: state_s = state_r;
        endcase
    end

    // Log control; a pop on an empty FIFO is ignored so a same-edge push still lands
    always_comb begin
        push_s  = (state_r == ST_RUN) && MemWrite;
        pop_s   = log_pop && (count_r != {CW{1'b0}});
        full_s  = (count_r == DEPTH_C);
        wr_en_s = push_s && (!full_s || pop_s);
    end

    // State, verdict and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_RUN;
            fail_code_r   <= 32'd0;
            cycle_count_r <= 32'd0;
            store_count_r <= 32'd0;
        end else begin
            state_r     <= state_s;
            fail_code_r <= fail_code_s;
            if (state_r == ST_RUN) begin
                cycle_count_r <= cyc_inc_s;
                store_count_r <= store_count_r + {31'd0, MemWrite};
            end
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (wr_en_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            if (pop_s)   rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            case ({wr_en_s, pop_s})
                2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
            if (push_s && full_s && !pop_s) overflow_r <= 1'b1;
        end
    end

    // Log storage; contents are don't-care while empty so no reset is needed
    always_ff @(posedge clk) begin
        if (wr_en_s) mem_r[wr_ptr_r] <= {Adr, WriteData};
    end

    assign done         = (state_r != ST_RUN);
    assign pass         = (state_r == ST_PASS);
    assign timed_out    = (state_r == ST_TIMEOUT);
    assign fail_code    = fail_code_r;
    assign cycle_count  = cycle_count_r;
    assign store_count  = store_count_r;
    assign log_adr      = mem_r[rd_ptr_r][63:32];
    assign log_data     = mem_r[rd_ptr_r][31:0];
    assign log_empty    = (count_r == {CW{1'b0}});
    assign log_full     = full_s;
    assign log_overflow = overflow_r;

endmodule

// File: tb/tb_run_monitor.sv
// Self-checking bench for run_monitor: scenario tasks with a scoreboard queue
// of expected store-log entries, built with TIMEOUT_CYCLES=20 and LOG_DEPTH=8.
module tb_run_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Adr = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic        MemWrite = 1'b0;
    logic        log_pop = 1'b0;
    logic        done, pass, timed_out, log_empty, log_full, log_overflow;
    logic [31:0] fail_code, cycle_count, store_count, log_adr, log_data;

    int errors = 0;
    int checks = 0;
    logic [63:0] sb[$];
    logic        model_run = 1'b1;
    logic [63:0] exp_e;

    run_monitor #(.TOHOST_ADDR(32'h0000_00FC), .TIMEOUT_CYCLES(20), .LOG_DEPTH(8)) dut (
        .clk(clk), .reset(reset), .Adr(Adr), .WriteData(WriteData), .MemWrite(MemWrite),
        .log_pop(log_pop), .done(done), .pass(pass), .timed_out(timed_out),
        .fail_code(fail_code), .cycle_count(cycle_count), .store_count(store_count),
        .log_adr(log_adr), .log_data(log_data), .log_empty(log_empty), .log_full(log_full),
        .log_overflow(log_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; MemWrite = 1'b0; log_pop = 1'b0;
        sb.delete(); model_run = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // one store on the next edge; the model logs it only while the run is live
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        Adr = a; WriteData = d; MemWrite = 1'b1;
        if (model_run) begin
            if (sb.size() < 8) sb.push_back({a, d});
            if (a == 32'hFC && d != 32'd0) model_run = 1'b0;
        end
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    task automatic pop_check(input string nm);
        checks++;
        if (log_empty !== 1'b0 || sb.size() == 0) begin
            errors++; $display("FAIL %s_nonempty: got log_empty=%b, required 0 (model %0d)", nm, log_empty, sb.size());
        end else begin
            exp_e = sb.pop_front();
            checks++;
            if ({log_adr, log_data} !== exp_e) begin
                errors++; $display("FAIL %s_entry: got %h/%h, required %h/%h", nm, log_adr, log_data, exp_e[63:32], exp_e[31:0]);
            end
        end
        log_pop = 1'b1;
        @(negedge clk);
        log_pop = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({done, pass, timed_out, log_empty, log_full, log_overflow} !== 6'b000100) begin
            errors++; $display("FAIL reset_flags: got %b, required 000100", {done, pass, timed_out, log_empty, log_full, log_overflow});
        end
        checks++;
        if ({fail_code, cycle_count, store_count} !== 96'd0) begin
            errors++; $display("FAIL reset_counts: got %h %h %h, required 0 0 0", fail_code, cycle_count, store_count);
        end
    endtask

    task automatic test_pass();
        do_reset();
        store(32'h10, 32'hA);
        store(32'h14, 32'hB);
        store(32'hFC, 32'h1);
        checks++;
        if ({done, pass, timed_out} !== 3'b110) begin
            errors++; $display("FAIL pass_verdict: got done/pass/to=%b, required 110", {done, pass, timed_out});
        end
        checks++;
        if (store_count !== 32'd3 || cycle_count !== 32'd3) begin
            errors++; $display("FAIL pass_counts: got stores=%0d cycles=%0d, required 3 3", store_count, cycle_count);
        end
        store(32'h20, 32'h7);
        checks++;
        if (store_count !== 32'd3 || cycle_count !== 32'd3) begin
            errors++; $display("FAIL pass_frozen: got stores=%0d cycles=%0d, required 3 3", store_count, cycle_count);
        end
        for (int i = 0; i < 3; i++) pop_check("pass_pop");
        checks++;
        if (log_empty !== 1'b1) begin
            errors++; $display("FAIL pass_drained: got log_empty=%b, required 1", log_empty);
        end
    endtask

    task automatic test_fail();
        do_reset();
        store(32'hFC, 32'h0);
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL fail_zero_ignored: got done=%b, required 0", done);
        end
        store(32'hFC, 32'h2A);
        checks++;
        if ({done, pass, timed_out} !== 3'b100 || fail_code !== 32'h2A) begin
            errors++; $display("FAIL fail_verdict: got %b code=%h, required 100 code=0000002a", {done, pass, timed_out}, fail_code);
        end
        checks++;
        if (store_count !== 32'd2) begin
            errors++; $display("FAIL fail_stores: got %0d, required 2", store_count);
        end
        pop_check("fail_pop");
        pop_check("fail_pop");
    endtask

    task automatic test_timeout();
        do_reset();
        repeat (19) @(negedge clk);
        checks++;
        if (timed_out !== 1'b0 || cycle_count !== 32'd19) begin
            errors++; $display("FAIL to_before: got to=%b cycles=%0d, required 0 19", timed_out, cycle_count);
        end
        @(negedge clk);
        checks++;
        if ({done, pass, timed_out} !== 3'b101 || cycle_count !== 32'd20) begin
            errors++; $display("FAIL to_edge: got %b cycles=%0d, required 101 20", {done, pass, timed_out}, cycle_count);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (cycle_count !== 32'd20 || timed_out !== 1'b1) begin
            errors++; $display("FAIL to_hold: got cycles=%0d to=%b, required 20 1", cycle_count, timed_out);
        end
    endtask

    task automatic test_tohost_at_limit();
        do_reset();
        repeat (19) @(negedge clk);
        store(32'hFC, 32'h1);
        checks++;
        if ({pass, timed_out} !== 2'b10 || cycle_count !== 32'd20) begin
            errors++; $display("FAIL limit_pass: got pass/to=%b cycles=%0d, required 10 20", {pass, timed_out}, cycle_count);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 10; i++) store(32'h100 + 32'(i * 4), 32'(i + 1));
        checks++;
        if ({log_full, log_overflow} !== 2'b11 || store_count !== 32'd10) begin
            errors++; $display("FAIL ovf_flags: got full/ovf=%b stores=%0d, required 11 10", {log_full, log_overflow}, store_count);
        end
        // simultaneous push and pop on a full FIFO
        checks++;
        exp_e = sb.pop_front();
        if ({log_adr, log_data} !== exp_e) begin
            errors++; $display("FAIL ovf_head: got %h/%h, required %h/%h", log_adr, log_data, exp_e[63:32], exp_e[31:0]);
        end
        sb.push_back({32'h200, 32'h55});
        Adr = 32'h200; WriteData = 32'h55; MemWrite = 1'b1; log_pop = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0; log_pop = 1'b0;
        checks++;
        if (log_full !== 1'b1 || store_count !== 32'd11) begin
            errors++; $display("FAIL ovf_pushpop: got full=%b stores=%0d, required 1 11", log_full, store_count);
        end
        for (int i = 0; i < 8; i++) pop_check("ovf_pop");
        checks++;
        if ({log_empty, log_overflow} !== 2'b11) begin
            errors++; $display("FAIL ovf_drained: got empty/ovf=%b, required 11", {log_empty, log_overflow});
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        store(32'h10, 32'h5);
        store(32'hFC, 32'h1);
        checks++;
        if (pass !== 1'b1 || log_empty !== 1'b0) begin
            errors++; $display("FAIL ar_setup: got pass=%b empty=%b, required 1 0", pass, log_empty);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({done, pass, timed_out, log_empty, log_full, log_overflow} !== 6'b000100 ||
            {fail_code, cycle_count, store_count} !== 96'd0) begin
            errors++; $display("FAIL ar_immediate: got flags=%b counts=%h %h %h, required 000100 0 0 0",
                {done, pass, timed_out, log_empty, log_full, log_overflow}, fail_code, cycle_count, store_count);
        end
        sb.delete(); model_run = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (cycle_count !== 32'd1 || store_count !== 32'd0 || done !== 1'b0) begin
            errors++; $display("FAIL ar_restart: got cycles=%0d stores=%0d done=%b, required 1 0 0", cycle_count, store_count, done);
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_timeout();
        test_tohost_at_limit();
        test_overflow();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
